// File: rtl/mcb_dat_burst_path_if.sv
// MCB-side bus of the burst data path: write word/enables/load, read word/valid,
// write handshake status and optional read parity.
interface mcb_dat_burst_path_if #(
  parameter int SDR_D_W = 16,
  parameter int RATIO   = 2
);
  localparam int MCB_D_W = SDR_D_W * RATIO;
  localparam int MCB_B_W = MCB_D_W / 8;

  logic [MCB_D_W-1:0] mcb_wdat;
  logic [MCB_B_W-1:0] mcb_wbe;
  logic               d_wr_ld;
  logic               d_dp_ie;
  logic [MCB_D_W-1:0] mcb_rdat;
  logic               mcb_rvld;
  logic               wr_busy;
  logic               wr_err;
  logic [MCB_B_W-1:0] mcb_rpar;

  modport master (
    output mcb_wdat, mcb_wbe, d_wr_ld, d_dp_ie,
    input  mcb_rdat, mcb_rvld, wr_busy, wr_err, mcb_rpar
  );

  modport slave (
    input  mcb_wdat, mcb_wbe, d_wr_ld, d_dp_ie,
    output mcb_rdat, mcb_rvld, wr_busy, wr_err, mcb_rpar
  );
endinterface

// File: rtl/mcb_dat_burst_path.sv
// MCB <-> SDR DQ data path: serialises MCB words into RATIO SDR beats and reassembles reads.
// Optional per-byte even read parity on mcb_rpar is enabled by defining MCB_DAT_RD_PARITY_EN.
module mcb_dat_burst_path #(
  parameter  int SDR_D_W = 16,
  parameter  int RATIO   = 2,
  localparam int SDR_M_W = SDR_D_W / 8,
  localparam int MCB_D_W = SDR_D_W * RATIO,
  localparam int MCB_B_W = MCB_D_W / 8
) (
  input  logic               mcb_clk,
  input  logic               mcb_rst,
  input  logic               mcb_sclr_n,
  input  logic               i_ready,
  mcb_dat_burst_path_if.slave bus,
  output logic               dbf_dq_ie,
  input  logic [SDR_D_W-1:0] dbf_dq_i,
  output logic               dbf_dq_oe,
  output logic [SDR_D_W-1:0] dbf_dq_o,
  output logic [SDR_M_W-1:0] sdr_dqm
);

  localparam int            CW      = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int            NSLOT   = 1 << CW;
  localparam logic [CW-1:0] LAST    = CW'(RATIO - 1);
  localparam logic [0:0]    ST_IDLE  = 1'b0;
  localparam logic [0:0]    ST_SHIFT = 1'b1;

  // ---------------- write path ----------------
  logic [0:0]         state_reg, state_next;
  logic [CW-1:0]      wcnt_reg, wcnt_next;
  logic [MCB_D_W-1:0] wdat_reg, wdat_next;
  logic [MCB_B_W-1:0] wbe_reg, wbe_next;
  logic               dq_oe_reg;
  logic [SDR_D_W-1:0] dq_o_reg;
  logic [SDR_M_W-1:0] dqm_reg, dqm_next;
  logic               wr_err_reg;

  logic               wr_last, wr_accept, wr_reject;
  logic               beat_drive;
  logic [CW-1:0]      beat_idx;
  logic [MCB_D_W-1:0] src_dat;
  logic [MCB_B_W-1:0] src_be;
  logic [SDR_D_W-1:0] beat_dat_arr [NSLOT];
  logic [SDR_M_W-1:0] beat_be_arr  [NSLOT];
  logic [SDR_D_W-1:0] beat_dat;
  logic [SDR_M_W-1:0] beat_be;

  // With RATIO = 1 the single beat is always the last one, so loads are never rejected.
  assign wr_last   = (state_reg == ST_SHIFT) && (wcnt_reg == LAST);
  assign wr_accept = bus.d_wr_ld && ((state_reg == ST_IDLE) || wr_last);
  assign wr_reject = bus.d_wr_ld && (state_reg == ST_SHIFT) && !wr_last;

  always_comb begin
    state_next = state_reg;
    wcnt_next  = wcnt_reg;
    wdat_next  = wdat_reg;
    wbe_next   = wbe_reg;
    beat_drive = 1'b0;
    beat_idx   = '0;
    src_dat    = wdat_reg;
    src_be     = wbe_reg;
    if (wr_accept) begin
      state_next = ST_SHIFT;
      wcnt_next  = '0;
      wdat_next  = bus.mcb_wdat;
      wbe_next   = bus.mcb_wbe;
      beat_drive = 1'b1;
      src_dat    = bus.mcb_wdat;
      src_be     = bus.mcb_wbe;
    end else if (state_reg == ST_SHIFT && !wr_last) begin
      wcnt_next  = wcnt_reg + 1'b1;
      beat_drive = 1'b1;
      beat_idx   = wcnt_reg + 1'b1;
    end else if (state_reg == ST_SHIFT) begin
      state_next = ST_IDLE;
    end
  end

  // Little-endian beat slicing of whichever word feeds the next beat.
  generate
    for (genvar gi = 0; gi < NSLOT; gi++) begin : g_beat
      if (gi < RATIO) begin : g_used
        assign beat_dat_arr[gi] = src_dat[gi*SDR_D_W +: SDR_D_W];
        assign beat_be_arr[gi]  = src_be[gi*SDR_M_W +: SDR_M_W];
      end else begin : g_pad
        assign beat_dat_arr[gi] = '0;
        assign beat_be_arr[gi]  = '0;
      end
    end
  endgenerate

  assign beat_dat = beat_dat_arr[beat_idx];
  assign beat_be  = beat_be_arr[beat_idx];

  always_comb begin
    dqm_next = '0;
    if (!i_ready) begin
      dqm_next = '1;
    end else if (beat_drive) begin
      dqm_next = ~beat_be;
    end
  end

  always_ff @(posedge mcb_clk) begin
    if (mcb_rst) begin
      state_reg  <= ST_IDLE;
      wcnt_reg   <= '0;
      wdat_reg   <= '0;
      wbe_reg    <= '0;
      dq_oe_reg  <= 1'b0;
      dq_o_reg   <= '0;
      dqm_reg    <= '1;
      wr_err_reg <= 1'b0;
    end else if (!mcb_sclr_n) begin
      state_reg  <= ST_IDLE;
      wcnt_reg   <= '0;
      wdat_reg   <= '0;
      wbe_reg    <= '0;
      dq_oe_reg  <= 1'b0;
      dq_o_reg   <= '0;
      dqm_reg    <= i_ready ? '0 : '1;
      wr_err_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      wcnt_reg   <= wcnt_next;
      wdat_reg   <= wdat_next;
      wbe_reg    <= wbe_next;
      dq_oe_reg  <= beat_drive;
      if (beat_drive) begin
        dq_o_reg <= beat_dat;
      end
      dqm_reg    <= dqm_next;
      wr_err_reg <= wr_reject;
    end
  end

  assign dbf_dq_oe   = dq_oe_reg;
  assign dbf_dq_o    = dq_o_reg;
  assign sdr_dqm     = dqm_reg;
  assign bus.wr_err  = wr_err_reg;
  assign bus.wr_busy = (RATIO > 1) ? (state_reg == ST_SHIFT) : 1'b0;

  // ---------------- read path ----------------
  logic [CW-1:0]      rcnt_reg;
  logic [MCB_D_W-1:0] rbuf_reg;
  logic [MCB_D_W-1:0] rdat_reg;
  logic               rvld_reg;
  logic [MCB_D_W-1:0] rd_word;
  logic               rd_last;

  assign dbf_dq_ie = bus.d_dp_ie;
  assign rd_last   = bus.d_dp_ie && (rcnt_reg == LAST);

  // Current beat merged into its slot so the completed word is ready on the last beat's edge.
  generate
    for (genvar gi = 0; gi < RATIO; gi++) begin : g_rslot
      assign rd_word[gi*SDR_D_W +: SDR_D_W] =
        (bus.d_dp_ie && rcnt_reg == CW'(gi)) ? dbf_dq_i : rbuf_reg[gi*SDR_D_W +: SDR_D_W];
    end
  endgenerate

  always_ff @(posedge mcb_clk) begin
    if (mcb_rst || !mcb_sclr_n) begin
      rcnt_reg <= '0;
      rbuf_reg <= '0;
      rdat_reg <= '0;
      rvld_reg <= 1'b0;
    end else begin
      rvld_reg <= 1'b0;
      if (rd_last) begin
        rdat_reg <= rd_word;
        rvld_reg <= 1'b1;
        rcnt_reg <= '0;
      end else if (bus.d_dp_ie) begin
        rbuf_reg <= rd_word;
        rcnt_reg <= rcnt_reg + 1'b1;
      end
    end
  end

  assign bus.mcb_rdat = rdat_reg;
  assign bus.mcb_rvld = rvld_reg;

`ifdef MCB_DAT_RD_PARITY_EN
  logic [MCB_B_W-1:0] rpar_reg;
  logic [MCB_B_W-1:0] rd_par;

  generate
    for (genvar gi = 0; gi < MCB_B_W; gi++) begin : g_par
      assign rd_par[gi] = ^rd_word[gi*8 +: 8];
    end
  endgenerate

  always_ff @(posedge mcb_clk) begin
    if (mcb_rst || !mcb_sclr_n) begin
      rpar_reg <= '0;
    end else if (rd_last) begin
      rpar_reg <= rd_par;
    end
  end

  assign bus.mcb_rpar = rpar_reg;
`else
  assign bus.mcb_rpar = '0;
`endif

endmodule

// File: tb/tb_mcb_dat_burst_path.sv
// Self-checking bench for mcb_dat_burst_path (SDR_D_W=16, RATIO=2): cycle vector table
// for the write/control outputs plus a read-word scoreboard driven by a small beat model.
module tb_mcb_dat_burst_path;
  localparam int SDR_D_W = 16;
  localparam int RATIO   = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        sclr_n;
  logic        i_ready;
  logic        dq_ie;
  logic [15:0] dq_i;
  logic        dq_oe;
  logic [15:0] dq_o;
  logic [1:0]  dqm;

  mcb_dat_burst_path_if #(.SDR_D_W(SDR_D_W), .RATIO(RATIO)) bus ();

  mcb_dat_burst_path #(.SDR_D_W(SDR_D_W), .RATIO(RATIO)) dut (
    .mcb_clk    (clk),
    .mcb_rst    (rst),
    .mcb_sclr_n (sclr_n),
    .i_ready    (i_ready),
    .bus        (bus),
    .dbf_dq_ie  (dq_ie),
    .dbf_dq_i   (dq_i),
    .dbf_dq_oe  (dq_oe),
    .dbf_dq_o   (dq_o),
    .sdr_dqm    (dqm)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ld;
    logic [31:0] wdat;
    logic [3:0]  wbe;
    logic        ie;
    logic [15:0] dqi;
    logic        rdy;
    logic        sclr;
    logic        e_oe;
    logic [15:0] e_dq;
    logic [1:0]  e_dqm;
    logic        e_busy;
    logic        e_err;
  } vec_t;

  typedef struct {
    logic [31:0] w;
    logic [3:0]  p;
  } rd_t;

  vec_t vecs[$];
  rd_t  rd_q[$];
  int   checks = 0;
  int   failures = 0;

  int          rcnt_m = 0;
  logic [31:0] rbuf_m = '0;
  logic [31:0] rdat_m = '0;

  function automatic logic [3:0] par_of(logic [31:0] w);
    logic [3:0] p;
    p = '0;
`ifdef MCB_DAT_RD_PARITY_EN
    for (int b = 0; b < 4; b++) p[b] = ^w[b*8 +: 8];
`endif
    return p;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic add(logic ld, logic [31:0] wdat, logic [3:0] wbe, logic ie, logic [15:0] dqi,
                     logic rdy, logic sclr, logic e_oe, logic [15:0] e_dq, logic [1:0] e_dqm,
                     logic e_busy, logic e_err);
    vec_t v;
    v.ld = ld; v.wdat = wdat; v.wbe = wbe; v.ie = ie; v.dqi = dqi; v.rdy = rdy; v.sclr = sclr;
    v.e_oe = e_oe; v.e_dq = e_dq; v.e_dqm = e_dqm; v.e_busy = e_busy; v.e_err = e_err;
    vecs.push_back(v);
  endtask

  task automatic step(vec_t v, int idx);
    logic done;
    rd_t  e;
    bus.d_wr_ld  = v.ld;
    bus.mcb_wdat = v.wdat;
    bus.mcb_wbe  = v.wbe;
    bus.d_dp_ie  = v.ie;
    dq_i         = v.dqi;
    i_ready      = v.rdy;
    sclr_n       = v.sclr;
    done = 1'b0;
    if (!v.sclr) begin
      rcnt_m = 0; rbuf_m = '0; rdat_m = '0;
    end else if (v.ie) begin
      rbuf_m[rcnt_m*16 +: 16] = v.dqi;
      if (rcnt_m == RATIO - 1) begin
        rdat_m = rbuf_m;
        e.w = rbuf_m;
        e.p = par_of(rbuf_m);
        rd_q.push_back(e);
        rcnt_m = 0;
        done = 1'b1;
      end else begin
        rcnt_m++;
      end
    end
    @(posedge clk);
    #1;
    $display("vec %0d ld=%b ie=%b dqi=%h rdy=%b sclr_n=%b -> oe=%b dq=%h dqm=%b busy=%b err=%b rvld=%b rdat=%h",
             idx, v.ld, v.ie, v.dqi, v.rdy, v.sclr, dq_oe, dq_o, dqm, bus.wr_busy, bus.wr_err,
             bus.mcb_rvld, bus.mcb_rdat);
    chk($sformatf("v%0d_oe", idx), 32'(dq_oe), 32'(v.e_oe));
    chk($sformatf("v%0d_dq_o", idx), 32'(dq_o), 32'(v.e_dq));
    chk($sformatf("v%0d_dqm", idx), 32'(dqm), 32'(v.e_dqm));
    chk($sformatf("v%0d_busy", idx), 32'(bus.wr_busy), 32'(v.e_busy));
    chk($sformatf("v%0d_err", idx), 32'(bus.wr_err), 32'(v.e_err));
    chk($sformatf("v%0d_rvld", idx), 32'(bus.mcb_rvld), 32'(done));
    chk($sformatf("v%0d_rdat_hold", idx), bus.mcb_rdat, rdat_m);
    chk($sformatf("v%0d_rpar_hold", idx), 32'(bus.mcb_rpar), 32'(par_of(rdat_m)));
    if (bus.mcb_rvld) begin
      if (rd_q.size() == 0) begin
        chk($sformatf("v%0d_unexpected_rvld", idx), 32'(bus.mcb_rvld), 32'd0);
      end else begin
        e = rd_q.pop_front();
        chk($sformatf("v%0d_sb_rdat", idx), bus.mcb_rdat, e.w);
        chk($sformatf("v%0d_sb_rpar", idx), 32'(bus.mcb_rpar), 32'(e.p));
      end
    end
  endtask

  initial begin
    rst = 1'b1; sclr_n = 1'b1; i_ready = 1'b0;
    bus.d_wr_ld = 1'b0; bus.mcb_wdat = '0; bus.mcb_wbe = '0; bus.d_dp_ie = 1'b0; dq_i = '0;

    //   ld  wdat          wbe    ie dqi       rdy sclr  oe dq        dqm   busy err
    add(0, 32'h0,         4'h0,   0, 16'h0,    1, 1,    0, 16'h0000, 2'b00, 0, 0);
    add(1, 32'hAABB_CCDD, 4'b1101,0, 16'h0,    1, 1,    1, 16'hCCDD, 2'b10, 1, 0);
    add(0, 32'h0,         4'h0,   0, 16'h0,    1, 1,    1, 16'hAABB, 2'b00, 1, 0);
    add(0, 32'h0,         4'h0,   0, 16'h0,    1, 1,    0, 16'hAABB, 2'b00, 0, 0);
    add(1, 32'hAABB_CCDD, 4'b1111,0, 16'h0,    1, 1,    1, 16'hCCDD, 2'b00, 1, 0);
    add(0, 32'h0,         4'h0,   0, 16'h0,    1, 1,    1, 16'hAABB, 2'b00, 1, 0);
    add(1, 32'h1111_2222, 4'b0111,0, 16'h0,    1, 1,    1, 16'h2222, 2'b00, 1, 0);
    add(0, 32'h0,         4'h0,   0, 16'h0,    1, 1,    1, 16'h1111, 2'b10, 1, 0);
    add(0, 32'h0,         4'h0,   0, 16'h0,    1, 1,    0, 16'h1111, 2'b00, 0, 0);
    add(1, 32'h0000_0001, 4'b1111,0, 16'h0,    1, 1,    1, 16'h0001, 2'b00, 1, 0);
    add(1, 32'hDEAD_DEAD, 4'b1111,0, 16'h0,    1, 1,    1, 16'h0000, 2'b00, 1, 1);
    add(0, 32'h0,         4'h0,   0, 16'h0,    1, 1,    0, 16'h0000, 2'b00, 0, 0);
    add(0, 32'h0,         4'h0,   1, 16'h5678, 1, 1,    0, 16'h0000, 2'b00, 0, 0);
    add(0, 32'h0,         4'h0,   0, 16'h0,    1, 1,    0, 16'h0000, 2'b00, 0, 0);
    add(0, 32'h0,         4'h0,   1, 16'h1234, 1, 1,    0, 16'h0000, 2'b00, 0, 0);
    add(0, 32'h0,         4'h0,   0, 16'h0,    1, 1,    0, 16'h0000, 2'b00, 0, 0);
    add(0, 32'h0,         4'h0,   1, 16'h9999, 1, 1,    0, 16'h0000, 2'b00, 0, 0);
    add(0, 32'h0,         4'h0,   0, 16'h0,    1, 0,    0, 16'h0000, 2'b00, 0, 0);
    add(0, 32'h0,         4'h0,   1, 16'hBEEF, 1, 1,    0, 16'h0000, 2'b00, 0, 0);
    add(0, 32'h0,         4'h0,   1, 16'hDEAD, 1, 1,    0, 16'h0000, 2'b00, 0, 0);
    add(1, 32'h0BAD_F00D, 4'b1011,1, 16'h4444, 1, 1,    1, 16'hF00D, 2'b00, 1, 0);
    add(0, 32'h0,         4'h0,   1, 16'h3333, 0, 1,    1, 16'h0BAD, 2'b11, 1, 0);
    add(0, 32'h0,         4'h0,   0, 16'h0,    1, 1,    0, 16'h0BAD, 2'b00, 0, 0);
    add(1, 32'h1234_5678, 4'b1111,0, 16'h0,    1, 1,    1, 16'h5678, 2'b00, 1, 0);
    add(0, 32'h0,         4'h0,   0, 16'h0,    1, 0,    0, 16'h0000, 2'b00, 0, 0);
    add(0, 32'h0,         4'h0,   0, 16'h0,    0, 1,    0, 16'h0000, 2'b11, 0, 0);
    add(0, 32'h0,         4'h0,   0, 16'h0,    1, 1,    0, 16'h0000, 2'b00, 0, 0);

    // Reset held two cycles with SDRAM not yet initialised.
    repeat (2) @(posedge clk);
    #1;
    $display("reset: oe=%b dq=%h dqm=%b rdat=%h", dq_oe, dq_o, dqm, bus.mcb_rdat);
    chk("rst_dqm", 32'(dqm), 32'(2'b11));
    chk("rst_oe", 32'(dq_oe), 32'd0);
    chk("rst_dq_o", 32'(dq_o), 32'd0);
    chk("rst_rdat", bus.mcb_rdat, 32'd0);
    chk("rst_rvld", 32'(bus.mcb_rvld), 32'd0);
    chk("rst_busy", 32'(bus.wr_busy), 32'd0);
    chk("rst_err", 32'(bus.wr_err), 32'd0);
    chk("rst_rpar", 32'(bus.mcb_rpar), 32'd0);

    // Out of reset but not ready: mask must stay asserted.
    rst = 1'b0;
    @(posedge clk);
    #1;
    $display("post-reset not ready: dqm=%b ie=%b", dqm, dq_ie);
    chk("notready_dqm", 32'(dqm), 32'(2'b11));

    // Pad input enable is a straight pass-through.
    bus.d_dp_ie = 1'b1;
    #1;
    chk("dq_ie_pass_hi", 32'(dq_ie), 32'd1);
    bus.d_dp_ie = 1'b0;
    #1;
    chk("dq_ie_pass_lo", 32'(dq_ie), 32'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i], i);
    end

    chk("rd_queue_drained", 32'(rd_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
